mem_port_arbiter: RTL

Shares one single-ported unified memory between the instruction-fetch stage and the data-memory stage of the 5-stage pipelined CPU. Each requester uses a req/ack handshake; the arbiter grants one transaction at a time using round-robin on ties, latches the granted request, and drives the shared memory port. It also produces the global pipeline `stall` and a sticky `err` that flags a memory timeout.

---
 rtl/mem_port_arbiter_pkg.sv | 24 ++
 rtl/mem_port_arbiter_if.sv | 41 ++++
 rtl/mem_port_arbiter_wdog.sv | 34 +++
 rtl/mem_port_arbiter.sv | 113 +++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the instruction/data memory port arbiter:
// state and last-served encodings, default timeout, and counter sizing.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

  // Which requester completed most recently; ties go to the other one.
  typedef enum logic {
    LAST_I = 1'b0,
    LAST_D = 1'b1
  } last_e;

  localparam int MAX_WAIT_DEFAULT = 15;

  // Width of a counter that must hold values 0..max_wait.
  function automatic int wdog_cnt_w(input int max_wait);
    return (max_wait < 2) ? 1 : $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data-stage and shared-memory signals around the arbiter.
// slave = arbiter view, master = surrounding pipeline and memory view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ack;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  logic              stall;
  logic              err;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
    output if_rdata, if_ack, dm_rdata, dm_ack,
    output mem_req, mem_we, mem_addr, mem_wdata, stall, err
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_ack, dm_rdata, dm_ack,
    input  mem_req, mem_we, mem_addr, mem_wdata, stall, err
  );

endinterface

// File: rtl/mem_port_arbiter_wdog.sv
// Memory-response watchdog: counts busy cycles without a memory ack and
// flags expiry in the cycle that would be the MAX_WAIT-th such cycle.
module mem_wdog
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = wdog_cnt_w(MAX_WAIT);

  logic [CNT_W-1:0] count;

  // Wait counter: cleared while idle, advanced on each unanswered busy cycle.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement or block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = en && (count == CNT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single unified memory port between instruction fetch and
// the data stage: round-robin on ties, latched request fields, watchdog
// timeout with sticky err, and the global pipeline stall.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);

  arb_state_e        state;
  last_e             last;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              err_q;

  logic busy;
  logic expired;
  logic done;
  logic grant_d;
  logic grant_i;

  assign busy = (state != IDLE);

  mem_wdog #(.MAX_WAIT(MAX_WAIT)) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (!busy),
    .en      (busy && !bus.mem_ack),
    .expired (expired)
  );

  // A memory ack wins over a simultaneous timeout; either ends the transaction.
  assign done = busy && (bus.mem_ack || expired);

  // Grant selection in IDLE: lone requester wins, ties go to whoever was not served last.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (bus.dm_req && (!bus.if_req || last == LAST_I)) begin
      grant_d = 1'b1;
    end else if (bus.if_req) begin
      grant_i = 1'b1;
    end
  end

  // Arbiter FSM with registered memory-port fields, last-served bit and sticky err.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      last        <= LAST_I;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state       <= BUSY_D;
            mem_req_q   <= 1'b1;
            mem_we_q    <= bus.dm_we;
            mem_addr_q  <= bus.dm_addr;
            mem_wdata_q <= bus.dm_wdata;
          end else if (grant_i) begin
            state       <= BUSY_I;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= bus.if_addr;
            mem_wdata_q <= '0;
          end
        end
        BUSY_I, BUSY_D: begin
          if (done) begin
            state     <= IDLE;
            mem_req_q <= 1'b0;
            last      <= (state == BUSY_D) ? LAST_D : LAST_I;
            if (!bus.mem_ack) begin
              err_q <= 1'b1;
            end
          end
        end
        default: begin
          state     <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.err       = err_q;

  assign bus.if_ack   = (state == BUSY_I) && done;
  assign bus.dm_ack   = (state == BUSY_D) && done;
  assign bus.if_rdata = ((state == BUSY_I) && bus.mem_ack) ? bus.mem_rdata : '0;
  assign bus.dm_rdata = ((state == BUSY_D) && bus.mem_ack && !mem_we_q) ? bus.mem_rdata : '0;
  assign bus.stall    = (bus.if_req && !bus.if_ack) || (bus.dm_req && !bus.dm_ack);

endmodule
